// File: rtl/d_cache_tag_array.sv
// d_cache_tag_array
//   N-way set-associative tag store for the data cache. Each way of each set
//   holds a tag, a valid bit and a dirty bit. Each set also holds a
//   round-robin replacement pointer. A lookup is accepted in one cycle and its
//   result (hit/way/victim) is registered on the next clock edge. Writes come
//   from the cache controller. An invalidate-all sweep runs after reset or on
//   request.
//
// Ports
//   clk, rst            clock (rising edge); synchronous active-high reset
//   ready               idle, accepting lookups/writes/invalidate requests
//   lk_valid/index/tag  lookup request
//   rs_valid/hit/way    lookup result; rs_way = hit way or victim way
//   rs_victim_valid/dirty/tag  victim entry state (zero on a hit)
//   wr_ena/index/way/tag/valid/dirty/fill  entry write; fill advances pointer
//   inv_req, inv_done   start invalidate-all sweep; pulse on its final cycle
module d_cache_tag_array #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int TAG_W = 55,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rs_valid,
  output logic             rs_hit,
  output logic [WAY_W-1:0] rs_way,
  output logic             rs_victim_valid,
  output logic             rs_victim_dirty,
  output logic [TAG_W-1:0] rs_victim_tag,
  input  logic             wr_ena,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic             wr_fill,
  input  logic             inv_req,
  output logic             inv_done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sweep_en;

  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [WAYS-1:0]  vld_mem [SETS];
  logic [WAYS-1:0]  dty_mem [SETS];
  logic [WAY_W-1:0] ptr_mem [SETS];

  logic             lk_acc, wr_acc;

  logic [TAG_W-1:0] tag_p0 [WAYS];
  logic [WAYS-1:0]  vld_set_p0, dty_set_p0;
  logic [WAY_W-1:0] ptr_p0;
  logic             hit_p0;
  logic [WAY_W-1:0] hit_way_p0, vic_way_p0;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_en = 1'b0;
    inv_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        sweep_en = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d  = IDLE;
          inv_done = 1'b1;
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == IDLE);

  // An invalidate request wins over a lookup or write in the same cycle.
  assign lk_acc = ready & lk_valid & ~inv_req & ~rst;
  assign wr_acc = ready & wr_ena   & ~inv_req & ~rst;

  // ---------------- stage p0: set read with write-first bypass ----------------
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      tag_p0[i] = tag_mem[lk_index][i];
    end
    vld_set_p0 = vld_mem[lk_index];
    dty_set_p0 = dty_mem[lk_index];
    ptr_p0     = ptr_mem[lk_index];
    if (wr_acc && (wr_index == lk_index)) begin
      tag_p0[wr_way]     = wr_tag;
      vld_set_p0[wr_way] = wr_valid;
      dty_set_p0[wr_way] = wr_dirty;
      if (wr_fill) begin
        ptr_p0 = wr_way + 1'b1;
      end
    end

    hit_p0     = 1'b0;
    hit_way_p0 = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (vld_set_p0[i] && (tag_p0[i] == lk_tag)) begin
        hit_p0     = 1'b1;
        hit_way_p0 = WAY_W'(i);
      end
    end

    // Descending scan so the lowest-numbered invalid way is the last to win.
    vic_way_p0 = ptr_p0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!vld_set_p0[i]) begin
        vic_way_p0 = WAY_W'(i);
      end
    end
  end

  // ---------------- stage p1: registered lookup result ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_valid        <= 1'b0;
      rs_hit          <= 1'b0;
      rs_way          <= '0;
      rs_victim_valid <= 1'b0;
      rs_victim_dirty <= 1'b0;
      rs_victim_tag   <= '0;
    end else begin
      rs_valid <= lk_acc;
      if (lk_acc) begin
        rs_hit <= hit_p0;
        if (hit_p0) begin
          rs_way          <= hit_way_p0;
          rs_victim_valid <= 1'b0;
          rs_victim_dirty <= 1'b0;
          rs_victim_tag   <= '0;
        end else begin
          rs_way          <= vic_way_p0;
          rs_victim_valid <= vld_set_p0[vic_way_p0];
          rs_victim_dirty <= dty_set_p0[vic_way_p0];
          rs_victim_tag   <= tag_p0[vic_way_p0];
        end
      end
    end
  end

  // ---------------- storage update ----------------
  // Sweep clears state bits and the pointer only; tags are left as-is since
  // they are meaningless without the valid bit.
  always_ff @(posedge clk) begin
    if (sweep_en) begin
      vld_mem[cnt_q] <= '0;
      dty_mem[cnt_q] <= '0;
      ptr_mem[cnt_q] <= '0;
    end else if (wr_acc) begin
      vld_mem[wr_index][wr_way] <= wr_valid;
      dty_mem[wr_index][wr_way] <= wr_dirty;
      if (wr_fill) begin
        ptr_mem[wr_index] <= wr_way + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      tag_mem[wr_index][wr_way] <= wr_tag;
    end
  end

endmodule

// File: doc/d_cache_tag_array.md
Name: d_cache_tag_array

Overview:
Parametrised N-way set-associative tag store for the data cache. It succeeds the single-way 64-entry tag RAM. Per way, each entry holds a tag, a valid bit and a dirty bit, and each set holds a round-robin replacement pointer. It performs a registered lookup with tag compare and victim selection, accepts fill and dirty updates from the cache controller, and runs an invalidate-all sweep after reset or on request.

Parameters:
WAYS, 2, number of ways; power of two, 2..8; WAY_W = clog2(WAYS).
SETS, 64, number of sets; power of two, 4..256; IDX_W = clog2(SETS).
TAG_W, 55, tag width in bits.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
ready  out  1  high when idle; lookups and writes are accepted only while high.
lk_valid  in  1  lookup request; sampled only when ready=1.
lk_index  in  IDX_W  set index of the lookup.
lk_tag  in  TAG_W  tag to compare.
rs_valid  out  1  lookup result valid; exactly one cycle after an accepted lookup.
rs_hit  out  1  some valid way's tag matched lk_tag.
rs_way  out  WAY_W  hit way if rs_hit=1, else victim way.
rs_victim_valid  out  1  valid bit of the victim way (0 if rs_hit=1).
rs_victim_dirty  out  1  dirty bit of the victim way (0 if rs_hit=1).
rs_victim_tag  out  TAG_W  tag of the victim way (0 if rs_hit=1).
wr_ena  in  1  entry write; honoured only when ready=1.
wr_index  in  IDX_W  set to write.
wr_way  in  WAY_W  way to write.
wr_tag  in  TAG_W  new tag.
wr_valid  in  1  new valid bit.
wr_dirty  in  1  new dirty bit.
wr_fill  in  1  write is a line fill; advances that set's replacement pointer.
inv_req  in  1  start an invalidate-all sweep; sampled only when ready=1.
inv_done  out  1  one-cycle pulse on the final sweep cycle.

Behaviour:
- FSM has two states: IDLE and SWEEP. The sweep counter is IDX_W bits wide.
- rst=1: state=SWEEP, counter=0, ready=0, rs_valid=0, rs_hit=0, rs_way=0, all rs_victim_* = 0, inv_done=0. These apply on the next clk edge and hold while rst is high.
- SWEEP: each cycle, clear valid and dirty in every way of set[counter] and clear that set's pointer; tags are not cleared. Then counter increments. When counter=SETS-1, go to IDLE and pulse inv_done in that same cycle. Total time is exactly SETS cycles with ready=0.
- rst asserted mid-sweep restarts the sweep at counter=0.
- IDLE with inv_req=1: enter SWEEP with counter=0. inv_req has priority over lk_valid and wr_ena in the same cycle; those are dropped.
- Lookup: the set is read in the cycle of acceptance, and results register on the next edge.
  - rs_hit = OR over ways of (valid & tag==lk_tag). At most one way may match; the controller guarantees this.
  - Victim = lowest-numbered invalid way, else the set's replacement pointer.
- Write: updates the entry at the clk edge. If wr_fill=1, the set pointer becomes (wr_way+1) mod WAYS.
- Write and lookup in the same cycle to the same set: lookup sees the post-write contents (write-first bypass). This covers hit, victim and pointer.
- Write and lookup to different sets in the same cycle are independent.
- While ready=0: lk_valid and wr_ena are ignored, and rs_valid=0 on the following cycle.
- Outputs hold their last values when rs_valid=0, except after rst.

Test Plan:
- Reset: assert rst for 1 cycle with SETS=64 → ready=0 for 64 cycles, inv_done pulse on the 64th, then ready=1. A lookup of any index then gives rs_hit=0, rs_way=0, rs_victim_valid=0.
- Fill/hit: write idx 5, way 1, tag 0x1234, valid=1, fill=1; then look up idx 5 tag 0x1234 → rs_hit=1, rs_way=1. Look up tag 0x1235 → rs_hit=0, rs_way=0 (way 0 invalid).
- Replacement: fill idx 7 way 0 (tag A) and way 1 (tag B), with way 1 dirty. Lookup miss → rs_way=0 (pointer = 0 after wrap), victim_tag=A, victim_dirty=0. Fill way 0 → next miss gives rs_way=1, victim_dirty=1, victim_tag=B.
- Bypass: in the same cycle, write idx 3 way 0 tag 0x55 valid=1 and look up idx 3 tag 0x55 → rs_hit=1, rs_way=0 on the next cycle.
- Invalidate: populate several sets, pulse inv_req alongside lk_valid → lookup dropped (rs_valid=0) and ready=0 for SETS cycles. All later lookups miss with victim_valid=0; previously dirty ways report victim_dirty=0.
- Reset mid-sweep: assert rst at counter=30 → counter restarts and inv_done arrives 64 cycles after rst deasserts, not earlier.
